i2s_rx: RTL and testbench
=========================

Name: i2s_rx

Overview:
- I2S audio receiver for the ADC input (audio_adc). It is the receive-side counterpart of the core's I2S DAC generator.
- Samples the externally timed SCLK/LRCK/SDATA lines in the clk domain (clk_74a at top level) and deframes 64fs stereo words.
- Presents left-aligned left/right samples with a one-cycle valid strobe to downstream core logic.

Parameters:
- DATA_WIDTH, 16, bits kept per channel, MSB-first; remaining bits of each word discarded.
- FRAME_BITS, 32, expected bits per channel word; used for framing check only.
- SYNC_STAGES, 2, synchronizer depth on SCLK/LRCK/SDATA; minimum 2.

Ports:
- clk  in  1  system clock; must be ≥ 8× SCLK frequency (74.25 MHz vs 3.072 MHz nominal).
- reset_n  in  1  asynchronous, active-low reset.
- i2s_sclk  in  1  bit clock, asynchronous to clk.
- i2s_lrck  in  1  word select; 0 = left, 1 = right.
- i2s_sdata  in  1  serial data (audio_adc).
- sample_l  out  DATA_WIDTH  last complete left sample.
- sample_r  out  DATA_WIDTH  last complete right sample.
- sample_valid  out  1  one-clk pulse when a new L/R pair is presented.
- locked  out  1  high once frame alignment is acquired.

Behaviour:
- Decided: one clock (clk); reset_n is asynchronous and active-low.
- Reset values: all outputs 0, state SYNC, bit_cnt 0, shift register 0.
- Input capture: each input passes through SYNC_STAGES flops. SCLK rising edge is detected as synced=1 while the previous synced value=0.
- All deframing acts only on detected SCLK rising edges (rise). At each rise, sample lrck_s and sdata_s; lrck_prev holds lrck_s from the previous rise.
- Word boundary: a rise where lrck_s != lrck_prev. The bit at that rise is the final (LSB) bit of the word for channel lrck_prev.
- Bit placement within a word: bit with index bit_cnt is written to word[DATA_WIDTH-1-bit_cnt] only while bit_cnt < DATA_WIDTH. Short words are therefore left-aligned and zero-padded; long words are truncated.
- At a boundary: the bit is stored, the word completes, and then word and bit_cnt are cleared for the new channel. Otherwise bit_cnt increments, saturating at 63.
- State machine:
  - SYNC: ignore data until the first boundary; at that boundary go to LEFT if the new lrck is 0, else WAIT_L.
  - WAIT_L: wait for the boundary that starts a left word (lrck becomes 0), then go to LEFT.
  - LEFT: on boundary, latch word into left holding register, go to RIGHT.
  - RIGHT: on boundary, load sample_l ← left holding, sample_r ← completed word, pulse sample_valid, go to LEFT.
- locked: set on first entry to LEFT; cleared only by reset.
- Latency: sample_valid asserts on the clk edge after the detected rise that carries the right-word LSB; total ≤ SYNC_STAGES+2 clk from the pin transition. sample_l and sample_r are stable from that edge until the next valid.
- sample_valid is never asserted for two consecutive clk cycles.
- SCLK stopped: outputs hold; no timeout.
- LRCK glitch mid-word: treated as a boundary; the resulting short word is delivered zero-padded (see framing check).
- Reset mid-word: immediate return to SYNC; the partial word is discarded.

Optional Feature:
- Macro: I2S_RX_FRAMING_CHECK_EN.
- Enabled: adds ports frame_err (out, 1) and frame_err_cnt (out, 8).
  - At every boundary outside SYNC, if the completed word's bit count != FRAME_BITS, frame_err pulses for one clk on the same edge the word completes.
  - frame_err_cnt increments, saturating at 255.
  - Data delivery is unchanged.
- Disabled: the ports and logic are absent.

Decomposition:
- Shared package i2s_pkg holds:
  - the state enum (SYNC, WAIT_L, LEFT, RIGHT);
  - constant I2S_FRAME_BITS_DEFAULT = 32;
  - channel encoding constants LRCK_LEFT = 0, LRCK_RIGHT = 1.
- One sub-module, i2s_sync_edge: N-stage synchronizer plus rising-edge detector, instantiated for SCLK. LRCK and SDATA use its synchronizer output only.

Test Plan:
- Nominal 64fs, SCLK = 3.072 MHz, L = 16'hA5C3, R = 16'h5A3C, 16 trailing zero bits per word → one valid per frame with sample_l = A5C3, sample_r = 5A3C; locked = 1 after the first left word.
- Reset released mid-right-word, followed by two full frames → no valid until the first complete left+right pair; that pair is reported exactly.
- Short words of 12 bits per channel, L = 12'hFFF, R = 12'h801 → sample_l = 16'hFFF0, sample_r = 16'h8010; with the macro enabled, frame_err pulses twice per frame and frame_err_cnt = 2 after one frame.
- Long words of 48 bits with MSBs 16'h1234 → sample = 1234 (excess truncated); frame_err pulses when the macro is enabled.
- SCLK stopped for 10 µs mid-word, then resumed → outputs hold, no valid during the stop; decoding continues correctly with the word completing on resume.
- 300 malformed words with the macro enabled → frame_err_cnt saturates at 255 and does not wrap.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S receive definitions: deframer states, channel encoding, default word length.
`timescale 1ns/1ps
package i2s_pkg;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    WAIT_L = 2'd1,
    LEFT   = 2'd2,
    RIGHT  = 2'd3
  } i2s_state_t;

  localparam int   I2S_FRAME_BITS_DEFAULT = 32;
  localparam logic LRCK_LEFT              = 1'b0;
  localparam logic LRCK_RIGHT             = 1'b1;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-stage synchronizer for one edge-detected line plus WIDTH data lines.
// Latency: STAGES clk to data_out, rise one cycle wide; no backpressure (free-running).
`timescale 1ns/1ps
module i2s_sync_edge #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             edge_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             rise
);

  // Bit 0 of every stage carries edge_in, upper bits carry data_in.
  logic [STAGES-1:0][WIDTH:0] stg;
  logic                       edge_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg       <= '0;
      edge_prev <= 1'b0;
    end else begin
      stg       <= {stg[STAGES-2:0], {data_in, edge_in}};
      edge_prev <= stg[STAGES-1][0];
    end
  end

  assign data_out = stg[STAGES-1][WIDTH:1];
  assign rise     = stg[STAGES-1][0] & ~edge_prev;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: deframes 64fs stereo words from asynchronous SCLK/LRCK/SDATA into left-aligned L/R samples.
// Latency: sample_valid <= SYNC_STAGES+2 clk after the right-word LSB; no backpressure, samples hold until next valid.
// I2S_RX_FRAMING_CHECK_EN adds frame_err / frame_err_cnt for words whose length differs from FRAME_BITS.
`timescale 1ns/1ps
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAME_BITS  = I2S_FRAME_BITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i2s_sclk,
  input  logic                  i2s_lrck,
  input  logic                  i2s_sdata,
  output logic [DATA_WIDTH-1:0] sample_l,
  output logic [DATA_WIDTH-1:0] sample_r,
  output logic                  sample_valid,
  output logic                  locked
`ifdef I2S_RX_FRAMING_CHECK_EN
  ,
  output logic                  frame_err,
  output logic [7:0]            frame_err_cnt
`endif
);

  logic [1:0]            data_s;
  logic                  sclk_rise;
  logic                  lrck_s;
  logic                  sdata_s;
  logic                  lrck_prev;
  logic                  boundary;
  logic [5:0]            bit_cnt;
  logic [5:0]            bit_cnt_inc;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] word_next;
  logic [DATA_WIDTH-1:0] left_hold;
  logic                  load_left;
  logic                  load_pair;
  i2s_state_t            state_q;
  i2s_state_t            state_d;

  i2s_sync_edge #(
    .WIDTH  (2),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .edge_in  (i2s_sclk),
    .data_in  ({i2s_sdata, i2s_lrck}),
    .data_out (data_s),
    .rise     (sclk_rise)
  );

  assign lrck_s      = data_s[0];
  assign sdata_s     = data_s[1];
  assign boundary    = sclk_rise && (lrck_s != lrck_prev);
  assign bit_cnt_inc = (bit_cnt == 6'd63) ? bit_cnt : bit_cnt + 6'd1;

  // Only the first DATA_WIDTH bits land; later bits of a long word fall off.
  always_comb begin
    word_next = word;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (int'(bit_cnt) == DATA_WIDTH - 1 - i) begin
        word_next[i] = sdata_s;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    load_left = 1'b0;
    load_pair = 1'b0;
    if (boundary) begin
      unique case (state_q)
        SYNC:   state_d = (lrck_s == LRCK_LEFT) ? LEFT : WAIT_L;
        WAIT_L: if (lrck_s == LRCK_LEFT) state_d = LEFT;
        LEFT: begin
          load_left = 1'b1;
          state_d   = RIGHT;
        end
        RIGHT: begin
          load_pair = 1'b1;
          state_d   = LEFT;
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lrck_prev    <= 1'b0;
      bit_cnt      <= '0;
      word         <= '0;
      left_hold    <= '0;
      sample_l     <= '0;
      sample_r     <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (sclk_rise) begin
        lrck_prev <= lrck_s;
        if (boundary) begin
          word    <= '0;
          bit_cnt <= '0;
        end else begin
          word    <= word_next;
          bit_cnt <= bit_cnt_inc;
        end
      end
      if (load_left) begin
        left_hold <= word_next;
      end
      if (load_pair) begin
        sample_l     <= left_hold;
        sample_r     <= word_next;
        sample_valid <= 1'b1;
      end
      if (state_d == LEFT) begin
        locked <= 1'b1;
      end
    end
  end

`ifdef I2S_RX_FRAMING_CHECK_EN
  // At a boundary bit_cnt still holds the index of the LSB, so length = bit_cnt + 1.
  localparam logic [5:0] LAST_IDX = 6'(FRAME_BITS - 1);

  logic word_bad;
  assign word_bad = boundary && (state_q != SYNC) && (bit_cnt != LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_err     <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      frame_err <= word_bad;
      if (word_bad && frame_err_cnt != 8'hFF) begin
        frame_err_cnt <= frame_err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: drives I2S frames, pushes expected L/R pairs, pops them on sample_valid.
`timescale 1ns/1ps
module tb_i2s_rx;

  localparam real T_CLK_HALF  = 6.734;
  localparam real T_SCLK_HALF = 162.76;

  logic        clk;
  logic        reset_n;
  logic        i2s_sclk;
  logic        i2s_lrck;
  logic        i2s_sdata;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_valid;
  logic        locked;
`ifdef I2S_RX_FRAMING_CHECK_EN
  logic        frame_err;
  logic [7:0]  frame_err_cnt;
`endif

  i2s_rx dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i2s_sclk     (i2s_sclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .locked       (locked)
`ifdef I2S_RX_FRAMING_CHECK_EN
    ,
    .frame_err     (frame_err),
    .frame_err_cnt (frame_err_cnt)
`endif
  );

  always #(T_CLK_HALF) clk = ~clk;

  int          checks;
  int          errors;
  int          pushed;
  int          valid_cnt;
  int          err_pulses;
  int          exp_ferr;
  logic        prev_valid;
  logic [31:0] sb_q[$];
  logic [31:0] sb_exp;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: first 16 bits of an n-bit MSB-first word, left-aligned, zero-padded.
  function automatic logic [15:0] align(input logic [63:0] val, input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < n && i < 16; i++) begin
      r[15-i] = val[n-1-i];
    end
    return r;
  endfunction

  task automatic send_bit(input logic b, input logic lr);
    i2s_sdata = b;
    i2s_lrck  = lr;
    #(T_SCLK_HALF);
    i2s_sclk = 1'b1;
    #(T_SCLK_HALF);
    i2s_sclk = 1'b0;
  endtask

  // I2S one-bit delay: the LSB of a word goes out with LRCK already flipped.
  task automatic send_span(input logic chan, input logic [63:0] val, input int n,
                           input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      send_bit(val[n-1-i], (i == n - 1) ? ~chan : chan);
    end
  endtask

  task automatic send_word(input logic chan, input logic [63:0] val, input int n);
    send_span(chan, val, n, 0, n);
  endtask

  task automatic send_frame(input logic [63:0] lv, input logic [63:0] rv, input int n);
    sb_q.push_back({align(lv, n), align(rv, n)});
    pushed++;
    if (n != 32) exp_ferr += 2;
    send_word(1'b0, lv, n);
    send_word(1'b1, rv, n);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #(40);
    chk("rst_sample_l", sample_l, 0);
    chk("rst_sample_r", sample_r, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_locked", locked, 0);
`ifdef I2S_RX_FRAMING_CHECK_EN
    chk("rst_ferr_cnt", frame_err_cnt, 0);
`endif
    err_pulses = 0;
    exp_ferr   = 0;
    #(3.3);
    reset_n = 1'b1;
    #(50);
  endtask

  task automatic drain();
    #(400);
    chk("sb_drain", sb_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset_n && sample_valid) begin
      valid_cnt++;
      chk("valid_gap", {31'd0, prev_valid}, 0);
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", valid_cnt, pushed);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("sample_l", sample_l, {16'd0, sb_exp[31:16]});
        chk("sample_r", sample_r, {16'd0, sb_exp[15:0]});
      end
    end
    prev_valid = sample_valid;
`ifdef I2S_RX_FRAMING_CHECK_EN
    if (reset_n && frame_err) err_pulses++;
`endif
  end

  initial begin
    #(1_000_000);
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [63:0] rv;
    clk        = 1'b0;
    reset_n    = 1'b0;
    i2s_sclk   = 1'b0;
    i2s_lrck   = 1'b0;
    i2s_sdata  = 1'b0;
    checks     = 0;
    errors     = 0;
    pushed     = 0;
    valid_cnt  = 0;
    err_pulses = 0;
    exp_ferr   = 0;
    prev_valid = 1'b0;

    // Nominal 64fs after a 33-bit right preamble that ends exactly at a left start.
    do_reset();
    send_word(1'b1, 64'h1_2345_6789, 33);
    chk("lock_preamble", locked, 1);
    for (int f = 0; f < 3; f++) begin
      send_frame({16'hA5C3, 16'h0}, {16'h5A3C, 16'h0}, 32);
    end
    drain();

    // Reset in the middle of a right word: that pair must never appear.
    rv = {32'h0, 16'h9999, 16'h0};
    send_word(1'b0, {16'h7777, 16'h0}, 32);
    send_span(1'b1, rv, 32, 0, 16);
    do_reset();
    send_span(1'b1, rv, 32, 16, 31);
    chk("lock_wait_l", locked, 0);
    send_span(1'b1, rv, 32, 31, 32);
    chk("lock_resume", locked, 1);
    send_frame({16'h0F0F, 16'h0}, {16'hF0F0, 16'h0}, 32);
    send_frame({16'hBEEF, 16'h0}, {16'hCAFE, 16'h0}, 32);
    drain();

    // Short 12-bit words.
    do_reset();
    send_word(1'b1, 64'h0, 33);
    send_frame(64'hFFF, 64'h801, 12);
`ifdef I2S_RX_FRAMING_CHECK_EN
    chk("ferr_cnt_short", frame_err_cnt, exp_ferr);
    chk("ferr_pulses_short", err_pulses, exp_ferr);
`endif
    send_frame(64'hFFF, 64'h801, 12);
    drain();

    // Long 48-bit words: excess bits truncated.
    send_frame({16'h1234, 32'hFFFF_FFFF}, {16'h1234, 32'h0000_FFFF}, 48);
    send_frame({16'h1234, 32'hFFFF_FFFF}, {16'h1234, 32'h0000_FFFF}, 48);
`ifdef I2S_RX_FRAMING_CHECK_EN
    chk("ferr_cnt_long", frame_err_cnt, exp_ferr);
    chk("ferr_pulses_long", err_pulses, exp_ferr);
`endif
    drain();

    // SCLK stopped mid right word for 10 us.
    rv = {32'h0, 16'h1357, 16'h0};
    sb_q.push_back({16'hC0DE, 16'h1357});
    pushed++;
    send_word(1'b0, {16'hC0DE, 16'h0}, 32);
    send_span(1'b1, rv, 32, 0, 10);
    #(10_000);
    chk("stop_valid_cnt", valid_cnt, pushed - 1);
    chk("stop_hold_l", sample_l, 16'h1234);
    chk("stop_hold_r", sample_r, 16'h1234);
    send_span(1'b1, rv, 32, 10, 32);
    drain();
    chk("total_valids", valid_cnt, pushed);

`ifdef I2S_RX_FRAMING_CHECK_EN
    // 300 two-bit words: counter must saturate, not wrap.
    do_reset();
    send_word(1'b1, 64'h0, 33);
    for (int f = 0; f < 150; f++) begin
      send_frame(64'h2, 64'h1, 2);
    end
    drain();
    chk("ferr_pulses_sat", err_pulses, 300);
    chk("ferr_cnt_sat", frame_err_cnt, (exp_ferr > 255) ? 255 : exp_ferr);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
